// File: rtl/eeprom_pkg.sv
// Shared definitions for the I2C EEPROM slave: FSM encoding, device ID and
// the control-byte match rule.
package eeprom_pkg;

  localparam int STATE_W = 4;
  localparam logic [3:0] DEV_ID = 4'b1010;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    DEV,
    DEV_ACK,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  // Control bits [3:1] below bit (addr_w-8) carry address; the rest must equal chip_sel.
  function automatic logic ctrl_match(input logic [7:0] ctrl, input logic [2:0] chip_sel,
                                      input int addr_w);
    logic [2:0] mask;
    mask = 3'b111 << (addr_w - 8);
    return (ctrl[7:4] == DEV_ID) && (((ctrl[3:1] ^ chip_sel) & mask) == 3'b000);
  endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_cond_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // Bit 0 = SCL, bit 1 = SDA.
  logic [1:0] w_in;
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic [1:0] r_prev;

  assign w_in = {i_sda, i_scl};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 2'b11;
      r_sync <= 2'b11;
      r_prev <= 2'b11;
    end else begin
      r_meta <= w_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sda      = r_sync[1];
  assign o_scl_rise = r_sync[0] & ~r_prev[0];
  assign o_scl_fall = ~r_sync[0] & r_prev[0];
  assign o_start    = r_sync[0] & r_prev[0] & r_prev[1] & ~r_sync[1];
  assign o_stop     = r_sync[0] & r_prev[0] & ~r_prev[1] & r_sync[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM slave: 24Cxx-style byte/page write, current/random/sequential read,
// with an internal write-busy period after each committed write.
module i2c_eeprom_slave
  import eeprom_pkg::*;
#(
  parameter int         ADDR_W     = 11,
  parameter int         PAGE_BYTES = 16,
  parameter logic [2:0] CHIP_SEL   = 3'b000,
  parameter int         TWR_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int BUSY_W = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_cond_detect u_cond (
    .clk       (clk),
    .rst       (rst),
    .i_scl     (scl_i),
    .i_sda     (sda_i),
    .o_sda     (w_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  state_t            r_state, w_state_next;
  logic [2:0]        r_cnt, w_cnt_next;
  logic              r_full, w_full_next;
  logic [7:0]        r_shift, w_shift_next;
  logic [7:0]        r_tx, w_tx_next;
  logic [2:0]        r_ctrl_hi, w_ctrl_hi_next;
  logic              r_mack, w_mack_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;
  logic              r_oe, w_oe_next;
  logic              r_wrote, w_wrote_next;
  logic              r_busy;
  logic [BUSY_W-1:0] r_busy_cnt;

  logic              w_mem_we;
  logic [7:0]        w_byte;
  logic [7:0]        r_rd_data;
  logic [10:0]       w_ctrl_addr;
  logic [ADDR_W-1:0] w_ptr_load;
  logic [ADDR_W-1:0] w_ptr_page;
  logic [ADDR_W-1:0] w_ptr_full;

  logic [7:0] r_mem [MEM_DEPTH];

  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_ctrl_addr = {r_ctrl_hi, r_shift};
  assign w_ptr_load  = w_ctrl_addr[ADDR_W-1:0];
  assign w_ptr_page  = (r_ptr & ~PAGE_MASK) | ((r_ptr + ADDR_W'(1)) & PAGE_MASK);
  assign w_ptr_full  = r_ptr + ADDR_W'(1);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_full_next    = r_full;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_ctrl_hi_next = r_ctrl_hi;
    w_mack_next    = r_mack;
    w_ptr_next     = r_ptr;
    w_oe_next      = r_oe;
    w_wrote_next   = r_wrote;
    w_mem_we       = 1'b0;

    if (w_start) begin
      w_state_next = DEV;
      w_cnt_next   = 3'd0;
      w_full_next  = 1'b0;
      w_oe_next    = 1'b0;
    end else if (w_stop) begin
      w_state_next = IDLE;
      w_cnt_next   = 3'd0;
      w_full_next  = 1'b0;
      w_oe_next    = 1'b0;
      w_wrote_next = 1'b0;
    end else begin
      case (r_state)
        DEV, ADDR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_next = w_byte;
            w_cnt_next   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_full_next = 1'b1;
              if (r_state == WDATA) begin
                w_mem_we     = 1'b1;
                w_ptr_next   = w_ptr_page;
                w_wrote_next = 1'b1;
              end
            end
          end else if (w_scl_fall && r_full) begin
            // A full byte is in r_shift; the 9th SCL period starts here.
            w_full_next = 1'b0;
            if (r_state == DEV) begin
              if (ctrl_match(r_shift, CHIP_SEL, ADDR_W) && !r_busy) begin
                w_state_next   = DEV_ACK;
                w_oe_next      = 1'b1;
                w_ctrl_hi_next = r_shift[3:1];
              end else begin
                w_state_next = WAIT_STOP;
              end
            end else if (r_state == ADDR) begin
              w_state_next = ADDR_ACK;
              w_oe_next    = 1'b1;
              w_ptr_next   = w_ptr_load;
            end else begin
              w_state_next = WDATA_ACK;
              w_oe_next    = 1'b1;
            end
          end
        end

        DEV_ACK: begin
          if (w_scl_fall) begin
            w_cnt_next = 3'd0;
            if (r_shift[0]) begin
              w_state_next = RDATA;
              w_tx_next    = r_rd_data;
              w_oe_next    = ~r_rd_data[7];
            end else begin
              w_state_next = ADDR;
              w_oe_next    = 1'b0;
            end
          end
        end

        ADDR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_next = WDATA;
            w_cnt_next   = 3'd0;
            w_oe_next    = 1'b0;
          end
        end

        RDATA: begin
          if (w_scl_rise) begin
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_full_next = 1'b1;
              w_ptr_next  = w_ptr_full;
            end
          end else if (w_scl_fall) begin
            if (r_full) begin
              w_full_next  = 1'b0;
              w_oe_next    = 1'b0;
              w_state_next = RDATA_ACK;
            end else begin
              w_oe_next = ~r_tx[3'd7 - r_cnt];
            end
          end
        end

        RDATA_ACK: begin
          if (w_scl_rise) begin
            w_mack_next = ~w_sda;
          end else if (w_scl_fall) begin
            if (r_mack) begin
              // Pointer advanced on the last data rise, so r_rd_data already holds the next byte.
              w_state_next = RDATA;
              w_cnt_next   = 3'd0;
              w_tx_next    = r_rd_data;
              w_oe_next    = ~r_rd_data[7];
            end else begin
              w_state_next = WAIT_STOP;
              w_oe_next    = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_full    <= 1'b0;
      r_shift   <= 8'd0;
      r_tx      <= 8'd0;
      r_ctrl_hi <= 3'd0;
      r_mack    <= 1'b0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_wrote   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_full    <= w_full_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_ctrl_hi <= w_ctrl_hi_next;
      r_mack    <= w_mack_next;
      r_ptr     <= w_ptr_next;
      r_oe      <= w_oe_next;
      r_wrote   <= w_wrote_next;
    end
  end

  // Busy only arms from idle, so bus activity during a write cycle cannot extend it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_busy_cnt <= '0;
    end else if (r_busy) begin
      if (r_busy_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
      end
    end else if (w_stop && r_wrote) begin
      r_busy     <= 1'b1;
      r_busy_cnt <= BUSY_W'(TWR_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
    r_rd_data <= r_mem[r_ptr];
  end

  assign sda_oe = r_oe;
  assign busy   = r_busy;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master on a wired-AND SDA.
module tb_i2c_eeprom_slave;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe, busy, sda_wire;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_rise = 0;
  int   t_fall = 0;
  logic busy_q = 1'b0;

  assign sda_wire = m_sda & ~sda_oe;

  i2c_eeprom_slave dut (
    .clk   (clk),
    .rst   (rst),
    .scl_i (m_scl),
    .sda_i (sda_wire),
    .sda_oe(sda_oe),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1 && busy_q === 1'b0) t_rise = cyc;
    if (busy === 1'b0 && busy_q === 1'b1) t_fall = cyc;
    busy_q = busy;
  end

  task automatic qtr();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b0; qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qtr();
    m_scl = 1'b1; qtr();
    m_sda = 1'b1;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; qtr();
    m_scl = 1'b1; qtr(); qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; qtr();
    m_scl = 1'b1; qtr();
    b = sda_wire; qtr();
    m_scl = 1'b0; qtr();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack);
  endtask

  task automatic wait_busy_done(output logic ok);
    int   n;
    logic rose;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    rose = (busy === 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    ok = rose && (busy === 1'b0);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    qtr();
    $display("test_reset: sda_oe=%b busy=%b", sda_oe, busy);
  endtask

  task automatic test_byte_write();
    logic       ack, ok;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_ctrl_ack: got %b expected 1", ack); end
    write_byte(8'h05, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_addr_ack: got %b expected 1", ack); end
    write_byte(8'h3C, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_data_ack: got %b expected 1", ack); end
    i2c_stop();
    wait_busy_done(ok);
    checks++;
    if (!ok || (t_fall - t_rise) != 1000) begin
      errors++; $display("FAIL bw_busy_len: got %0d cycles (ok=%b) expected 1000", t_fall - t_rise, ok);
    end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL bw_rd_ctrl_ack: got %b expected 1", ack); end
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL bw_readback: got %h expected 3c", d); end
    i2c_stop();
    qtr();
    $display("test_byte_write: wrote 3c to 005, busy %0d cycles, read %h", t_fall - t_rise, d);
  endtask

  task automatic test_page_wrap();
    logic       ack, ok;
    logic [7:0] d;
    logic [7:0] exp_d;
    int         k0;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    write_byte(8'h5A, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pw_pre_ack: got %b expected 1", ack); end
    i2c_stop();
    wait_busy_done(ok);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0E, ack);
    for (int k = 0; k < 18; k++) begin
      write_byte(8'(k), ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL pw_data_ack[%0d]: got %b expected 1", k, ack); end
    end
    i2c_stop();
    wait_busy_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pw_busy: busy cycle did not complete, got 0 expected 1"); end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    for (int a = 0; a < 17; a++) begin
      read_byte(d, a < 16);
      if (a == 16) begin
        exp_d = 8'h5A;
      end else begin
        k0 = (a + 2) & 15;
        exp_d = (k0 + 16 <= 17) ? 8'(k0 + 16) : 8'(k0);
      end
      checks++;
      if (d !== exp_d) begin errors++; $display("FAIL pw_mem[%03h]: got %h expected %h", a, d, exp_d); end
    end
    i2c_stop();
    qtr();
    $display("test_page_wrap: 18 bytes from 00e, readback 000..010 done");
  endtask

  task automatic test_seq_read_wrap();
    logic       ack, ok;
    logic [7:0] d0, d1, d2;
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hC3, ack);
    i2c_stop();
    wait_busy_done(ok);
    i2c_start();
    write_byte(8'hAE, ack);
    write_byte(8'hFF, ack);
    i2c_stop();
    qtr();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_no_busy: got %b expected 0", busy); end
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sr_ctrl_ack: got %b expected 1", ack); end
    read_byte(d0, 1'b1);
    read_byte(d1, 1'b1);
    read_byte(d2, 1'b0);
    checks++; if (d0 !== 8'hC3) begin errors++; $display("FAIL sr_7ff: got %h expected c3", d0); end
    checks++; if (d1 !== 8'h02) begin errors++; $display("FAIL sr_000: got %h expected 02", d1); end
    checks++; if (d2 !== 8'h03) begin errors++; $display("FAIL sr_001: got %h expected 03", d2); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL sr_release: got %b expected 0", sda_oe); end
    i2c_stop();
    qtr();
    $display("test_seq_read_wrap: %h %h %h", d0, d1, d2);
  endtask

  task automatic test_busy_mismatch();
    logic       ack, ok;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0D, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    qtr();
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL bm_busy_nack: got ack=%b expected 0", ack); end
    i2c_stop();
    qtr();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bm_still_busy: got %b expected 1", busy); end
    wait_busy_done(ok);
    checks++;
    if (!ok || (t_fall - t_rise) != 1000) begin
      errors++; $display("FAIL bm_busy_len: got %0d cycles (ok=%b) expected 1000", t_fall - t_rise, ok);
    end
    i2c_start();
    write_byte(8'hB0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL bm_id_nack: got ack=%b expected 0", ack); end
    write_byte(8'h0E, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL bm_addr_ignored: got ack=%b expected 0", ack); end
    write_byte(8'hEE, ack);
    i2c_stop();
    qtr();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bm_no_busy: got %b expected 0", busy); end
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h10) begin errors++; $display("FAIL bm_ptr_mem: got %h expected 10", d); end
    i2c_stop();
    qtr();
    $display("test_busy_mismatch: current read after nacks = %h", d);
  endtask

  task automatic test_abort();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_start();
    write_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ab_restart_ack: got %b expected 1", ack); end
    write_byte(8'h0D, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL ab_restart_read: got %h expected 77", d); end
    i2c_stop();
    qtr();
    i2c_start();
    write_byte(8'hA1, ack);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL ab_driving: got %b expected 1", sda_oe); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL ab_rst_release: got %b expected 0", sda_oe); end
    rst = 1'b0;
    m_sda = 1'b1;
    qtr();
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(d, 1'b0);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ab_ptr_zero: got %h expected 02", d); end
    i2c_stop();
    qtr();
    $display("test_abort: read after reset = %h", d);
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_page_wrap();
    test_seq_read_wrap();
    test_busy_mismatch();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 11, SHALL set the memory address width (legal range 8..11), giving 2^ADDR_W bytes.
REQ-003 Parameter PAGE_BYTES, default 16, SHALL set the write-page size (a power of 2, at most 2^ADDR_W).
REQ-004 Parameter CHIP_SEL, default 3'b000, SHALL be compared against control-byte bits [3:1] that are not used as address bits.
REQ-005 Parameter TWR_CYCLES, default 1000, SHALL set the length of the internal write-busy period in clk cycles.
REQ-006 Port list, one per line:
- clk  in  1  system clock, at least 8x the SCL frequency
- rst  in  1  synchronous active-high reset
- scl_i  in  1  I2C clock, asynchronous
- sda_i  in  1  I2C data as sensed on the wire, asynchronous
- sda_oe  out  1  1 = pull SDA low, 0 = release
- busy  out  1  internal write cycle in progress

Function
REQ-007 scl_i and sda_i SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized values.
REQ-008 START SHALL be detected as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high; both are recognized in every state.
REQ-009 Data bits SHALL be sampled on the detected SCL rise, MSB first.
REQ-010 sda_oe SHALL change only in the clk cycle after a detected SCL fall.
REQ-011 FSM states SHALL be IDLE, DEV, DEV_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT_STOP, with a 3-bit bit counter.
REQ-012 A START in any state SHALL enter DEV with the bit counter cleared; repeated START therefore works.
REQ-013 Control byte layout SHALL be: [7:4] = 4'b1010; [3:1] carries address bits [ADDR_W-1:8] in its low (ADDR_W-8) bits and CHIP_SEL in the remaining bits; [0] = R/W (1 = read).
REQ-014 On a control-byte match with busy=0, the block SHALL assert sda_oe for the 9th SCL period (DEV_ACK); otherwise it SHALL leave SDA released and go to WAIT_STOP.
REQ-015 After a write control byte, the address byte SHALL be ACKed and loaded into pointer bits [7:0], with bits [ADDR_W-1:8] taken from the control byte.
REQ-016 Each data byte SHALL be written to memory at the pointer on its 8th SCL rise and then ACKed.
REQ-017 During writes the pointer SHALL increment only its low log2(PAGE_BYTES) bits, so the address wraps within the page.
REQ-018 After a read control byte, the block SHALL drive memory[pointer] MSB first (sda_oe = ~bit); after each byte the pointer SHALL increment with full wrap from 2^ADDR_W-1 to 0.
REQ-019 For the master's ACK slot the block SHALL release SDA; a master ACK (SDA low) SHALL continue to the next byte, and a master NACK SHALL go to WAIT_STOP.
REQ-020 The pointer SHALL persist across transactions: a read with no address phase is a current-address read, and a write of ctrl + addr followed by repeated START and a read is a random read.
REQ-021 A STOP after at least one committed data byte SHALL set busy for exactly TWR_CYCLES clk cycles; a STOP or START during busy SHALL NOT restart the count.
REQ-022 A STOP in any state SHALL go to IDLE with sda_oe=0.

Reset
REQ-023 Reset SHALL set: state IDLE, sda_oe 0, busy 0, pointer 0, bit counter 0, busy counter 0, synchronizers to 1.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset during a transaction SHALL release SDA in the cycle after reset is sampled; the block then ignores the bus until the next START.

Structure
REQ-026 The state encoding, the 4'b1010 device ID and the STATE_W constant SHALL live in a shared package, eeprom_pkg.
REQ-027 A sub-module i2c_cond_detect SHALL contain the synchronizers and produce scl_rise, scl_fall, start and stop pulses.
REQ-028 Memory SHALL be a single-port inferred array.

Verification
REQ-029 Byte write: ctrl 0xA0, addr 0x05, data 0x3C, STOP -> 3 ACKs, busy high for 1000 cycles, then a random read of 0x005 returns 0x3C.
REQ-030 Page wrap: write 18 bytes 0..17 starting at 0x00E -> memory[0x00E]=0, [0x00F]=1, [0x000]=2 ... [0x00F]=17 overwritten last; 0x010 unchanged.
REQ-031 Sequential read wrap: pointer 0x7FF, ctrl 0xA1, master ACKs 2 bytes then NACKs the 3rd -> bytes from 0x7FF, 0x000, 0x001; SDA released after the 3rd.
REQ-032 Busy/mismatch: ctrl 0xA0 during busy -> NACK; ctrl 0xB0 -> NACK; neither changes the pointer or memory.
REQ-033 Abort: START mid-address byte -> new transaction accepted; rst mid-read -> sda_oe=0 next cycle, pointer 0.
